serial_word_receiver: RTL and testbench

- Downstream consumer of the serial shift register's `so`/`en` bit stream.
- Collects N serial bits (LSB first) into a parallel word and optionally checks a trailing parity bit.
- Delivers each word through a single-entry valid/ready holding register to the parallel datapath.
- Reports sync errors and overruns.

---
 rtl/serial_rx_pkg.sv | 37 +++
 rtl/serial_word_receiver_if.sv | 37 +++
 rtl/rx_hold_buf.sv | 62 ++++++
 rtl/serial_word_receiver.sv | 176 +++++++++++++++++
 tb/tb_serial_word_receiver.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_pkg
//   Shared types and helpers for the serial word receiver.
//
//   rx_state_t    : frame-level receive state (IDLE / DATA / PARITY).
//   parity_mode_t : parity sense; the odd sense flips the expected total.
//   cnt_width()   : width of a bit counter that must hold values 0..n.
//   parity_err_of : parity check applied when the parity bit arrives.
// -----------------------------------------------------------------------------
package serial_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_t;

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // acc is the XOR of all data bits of the frame, pbit the received parity
    // bit. With even parity the total number of ones must be even, so any
    // leftover 1 is an error; odd parity expects a leftover 1.
    function automatic logic parity_err_of(input logic acc,
                                           input logic pbit,
                                           input parity_mode_t mode);
        return acc ^ pbit ^ logic'(mode);
    endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_word_receiver_if
//   Parallel output side of the serial word receiver: a valid/ready word
//   channel carrying the received word and its parity status.
//
//   dout       : received word, bit 0 = first serial bit.
//   dout_valid : dout holds an unconsumed word.
//   dout_ready : consumer accepts dout while dout_valid is high.
//   parity_err : parity status of the word in dout (meaningful while valid).
//
//   Modports:
//     master : the receiver (drives dout/dout_valid/parity_err).
//     slave  : the consumer (drives dout_ready).
//   N must match the N of the receiver it is connected to.
// -----------------------------------------------------------------------------
interface serial_word_receiver_if #(
    parameter int N = 4
);
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         parity_err;

    modport master (
        output dout,
        output dout_valid,
        output parity_err,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  parity_err,
        output dout_ready
    );
endinterface

// File: rtl/rx_hold_buf.sv
// -----------------------------------------------------------------------------
// rx_hold_buf
//   Single-entry valid/ready holding register. A load is accepted when the
//   entry is empty or is being drained in the same cycle; otherwise the new
//   value is dropped and overrun pulses for one cycle. The held value never
//   changes while valid is high and ready is low.
//
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset.
//     load       : a new value is offered this cycle.
//     load_data  : the offered value (W bits).
//     ready      : consumer accepts the held value when valid=1.
//     data       : held value (registered).
//     valid      : an unconsumed value is held (registered).
//     overrun    : one-cycle pulse, an offered value was dropped (registered).
// -----------------------------------------------------------------------------
module rx_hold_buf #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);

    logic [W-1:0] data_reg;
    logic         valid_reg;
    logic         overrun_reg;

    // The entry is free if empty, or if its current value leaves this cycle.
    logic free;
    assign free = !valid_reg || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (load) begin
                if (free) begin
                    data_reg  <= load_data;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data    = data_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/serial_word_receiver.sv
// -----------------------------------------------------------------------------
// serial_word_receiver
//   Collects an LSB-first serial bit stream (qualified by en, framed by sof)
//   into N-bit words, optionally checks a trailing parity bit, and hands each
//   word to the parallel side through a single-entry valid/ready register.
//
//   Parameters:
//     N          : data bits per frame (2..32).
//     PARITY_EN  : 1 = one parity bit follows the data bits.
//     PARITY_ODD : 0 = even parity, 1 = odd parity.
//
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset.
//     en         : bit strobe; sin/sof are only looked at when en=1.
//     sin        : serial data bit.
//     sof        : start of frame, marks data bit 0.
//     sync_err   : one-cycle pulse, sof arrived inside a frame (frame restarts).
//     overrun    : one-cycle pulse, a completed word was dropped.
//     bus        : word channel (dout, dout_valid, dout_ready, parity_err).
// -----------------------------------------------------------------------------
module serial_word_receiver
    import serial_rx_pkg::*;
#(
    parameter int N          = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sin,
    input  logic                    sof,
    output logic                    sync_err,
    output logic                    overrun,
    serial_word_receiver_if.master  bus
);

    localparam int           CW         = cnt_width(N);
    localparam bit           HAS_PARITY = (PARITY_EN != 0);
    localparam parity_mode_t PMODE      = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_t     state_reg;
    logic [N-1:0]  shreg_reg;
    logic [CW-1:0] cnt_reg;
    logic          acc_reg;
    logic          sync_err_reg;

    // Shift register contents once the current sin has been shifted in.
    logic [N-1:0] shifted;
    assign shifted = {sin, shreg_reg[N-1:1]};

    // The bit being accepted now is data bit N-1 (the last data bit).
    logic last_data;
    assign last_data = (cnt_reg == CW'(N - 1));

    // -------------------------------------------------------------------------
    // Frame completion. This is decoded from the current state and inputs so
    // the holding register can capture the word on the same edge that accepts
    // the final bit; the word is then visible the cycle after the final en.
    // Without parity the final bit is not yet in shreg_reg, so the shifted
    // value is offered instead.
    // -------------------------------------------------------------------------
    logic         complete;
    logic [N-1:0] complete_word;
    logic         complete_perr;

    always_comb begin
        complete      = 1'b0;
        complete_word = shifted;
        complete_perr = 1'b0;
        if (en && !sof) begin
            if (state_reg == DATA && last_data && !HAS_PARITY) begin
                complete      = 1'b1;
                complete_word = shifted;
                complete_perr = 1'b0;
            end else if (state_reg == PARITY) begin
                complete      = 1'b1;
                complete_word = shreg_reg;
                complete_perr = parity_err_of(acc_reg, sin, PMODE);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM with shifter, bit counter and running parity. en=0 cycles are
    // pure stalls: nothing here moves without en. A sof seen inside a frame
    // (DATA or PARITY) restarts the frame with the current bit as bit 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            cnt_reg      <= '0;
            acc_reg      <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            sync_err_reg <= 1'b0;
            if (en) begin
                case (state_reg)
                    IDLE: begin
                        // Bits outside a frame are ignored until a sof.
                        if (sof) begin
                            shreg_reg <= shifted;
                            acc_reg   <= sin;
                            cnt_reg   <= CW'(1);
                            state_reg <= DATA;
                        end
                    end

                    DATA: begin
                        if (sof) begin
                            sync_err_reg <= 1'b1;
                            shreg_reg    <= shifted;
                            acc_reg      <= sin;
                            cnt_reg      <= CW'(1);
                        end else begin
                            shreg_reg <= shifted;
                            acc_reg   <= acc_reg ^ sin;
                            if (last_data) begin
                                cnt_reg   <= '0;
                                state_reg <= HAS_PARITY ? PARITY : IDLE;
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                    end

                    PARITY: begin
                        if (sof) begin
                            sync_err_reg <= 1'b1;
                            shreg_reg    <= shifted;
                            acc_reg      <= sin;
                            cnt_reg      <= CW'(1);
                            state_reg    <= DATA;
                        end else begin
                            // Word and parity status leave via the hold buffer.
                            state_reg <= IDLE;
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Holding register: parity status travels with the word in the top bit.
    // -------------------------------------------------------------------------
    logic [N:0] held_data;
    logic       held_valid;
    logic       hold_overrun;

    rx_hold_buf #(
        .W (N + 1)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data ({complete_perr, complete_word}),
        .ready     (bus.dout_ready),
        .data      (held_data),
        .valid     (held_valid),
        .overrun   (hold_overrun)
    );

    assign bus.dout       = held_data[N-1:0];
    assign bus.parity_err = held_data[N];
    assign bus.dout_valid = held_valid;
    assign sync_err       = sync_err_reg;
    assign overrun        = hold_overrun;

endmodule

// File: tb/tb_serial_word_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_word_receiver
//   Self-checking bench: instance A (N=4, even parity) runs a table of frames,
//   hand-written corner sequences and a randomized run against a frame-level
//   reference model; instance B (N=8, no parity) checks a single 0xA5 word.
// -----------------------------------------------------------------------------
module tb_serial_word_receiver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: N=4, PARITY_EN=1, even parity
    logic en, sin, sof, sync_err, overrun;
    serial_word_receiver_if #(.N(4)) bus_a ();

    serial_word_receiver #(.N(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sin      (sin),
        .sof      (sof),
        .sync_err (sync_err),
        .overrun  (overrun),
        .bus      (bus_a)
    );

    // Instance B: N=8, no parity
    logic en_b, sin_b, sof_b, sync_err_b, overrun_b;
    serial_word_receiver_if #(.N(8)) bus_b ();

    serial_word_receiver #(.N(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en_b),
        .sin      (sin_b),
        .sof      (sof_b),
        .sync_err (sync_err_b),
        .overrun  (overrun_b),
        .bus      (bus_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic f);
        en = 1'b1; sin = s; sof = f;
        tick();
        en = 1'b0; sof = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input int gap);
        for (int i = 0; i < 4; i++) begin
            send(d[i], i == 0);
            repeat (gap) tick();
        end
        send(p, 1'b0);
    endtask

    task automatic send_b(input logic s, input logic f);
        en_b = 1'b1; sin_b = s; sof_b = f;
        tick();
        en_b = 1'b0; sof_b = 1'b0;
    endtask

    // ---------------- reference model for the randomized run ----------------
    // Frame-level view: the bench knows which bit completes a frame and which
    // sof lands inside a frame; the model only tracks the one-word buffer.
    logic       m_valid;
    logic [3:0] m_word;
    logic       m_perr;

    task automatic step(input logic e, input logic s, input logic f, input logic r,
                        input bit comp, input logic [3:0] w, input logic pe, input bit syn);
        bit ov;
        en = e; sin = s; sof = f; bus_a.dout_ready = r;
        @(posedge clk);
        ov = 1'b0;
        if (comp) begin
            if (!m_valid || r) begin
                m_valid = 1'b1; m_word = w; m_perr = pe;
            end else begin
                ov = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        #1;
        chk("rnd_valid",    32'(bus_a.dout_valid), 32'(m_valid));
        chk("rnd_overrun",  32'(overrun),          32'(ov));
        chk("rnd_sync_err", 32'(sync_err),         32'(syn));
        if (m_valid) begin
            chk("rnd_dout", 32'(bus_a.dout),       32'(m_word));
            chk("rnd_perr", 32'(bus_a.parity_err), 32'(m_perr));
        end
    endtask

    function automatic logic rnd_ready();
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One frame bit, preceded by 0..2 en=0 cycles carrying random sin/sof.
    task automatic rbit(input logic s, input logic f, input bit comp,
                        input logic [3:0] w, input logic pe, input bit syn);
        int n;
        n = int'($urandom_range(0, 2));
        repeat (n) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        rnd_ready(), 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, s, f, rnd_ready(), comp, w, pe, syn);
    endtask

    // ---------------- table of single frames ----------------
    typedef struct {
        logic [3:0] d;
        logic       p;
        logic [3:0] exp_dout;
        logic       exp_perr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;

        tbl[0] = '{4'hD, 1'b1, 4'hD, 1'b0};
        tbl[1] = '{4'hD, 1'b0, 4'hD, 1'b1};
        tbl[2] = '{4'h0, 1'b0, 4'h0, 1'b0};
        tbl[3] = '{4'hF, 1'b0, 4'hF, 1'b0};
        tbl[4] = '{4'h3, 1'b1, 4'h3, 1'b1};
        tbl[5] = '{4'h8, 1'b1, 4'h8, 1'b0};

        en = 0; sin = 0; sof = 0; bus_a.dout_ready = 0;
        en_b = 0; sin_b = 0; sof_b = 0; bus_b.dout_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout",     32'(bus_a.dout),       32'h0);
        chk("reset_valid",    32'(bus_a.dout_valid), 32'h0);
        chk("reset_perr",     32'(bus_a.parity_err), 32'h0);
        chk("reset_sync_err", 32'(sync_err),         32'h0);
        chk("reset_overrun",  32'(overrun),          32'h0);
        rst = 1'b0;
        tick();

        // Table-driven frames, consumer always ready
        bus_a.dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].p, 0);
            chk("tbl_valid", 32'(bus_a.dout_valid), 32'h1);
            chk("tbl_dout",  32'(bus_a.dout),       32'(tbl[i].exp_dout));
            chk("tbl_perr",  32'(bus_a.parity_err), 32'(tbl[i].exp_perr));
            tick();
            chk("tbl_xfer",  32'(bus_a.dout_valid), 32'h0);
        end

        // Back-pressure and overrun
        bus_a.dout_ready = 1'b0;
        send_frame(4'hD, 1'b1, 0);
        chk("ovr_first_valid", 32'(bus_a.dout_valid), 32'h1);
        chk("ovr_first_dout",  32'(bus_a.dout),       32'hD);
        send_frame(4'h5, 1'b0, 0);
        chk("ovr_pulse",       32'(overrun),          32'h1);
        chk("ovr_keep_dout",   32'(bus_a.dout),       32'hD);
        chk("ovr_keep_perr",   32'(bus_a.parity_err), 32'h0);
        chk("ovr_keep_valid",  32'(bus_a.dout_valid), 32'h1);
        tick();
        chk("ovr_one_cycle",   32'(overrun),          32'h0);
        bus_a.dout_ready = 1'b1;
        tick();
        chk("ovr_drain",       32'(bus_a.dout_valid), 32'h0);

        // Sync error: sof on the third bit restarts the frame
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        chk("sync_pulse", 32'(sync_err), 32'h1);
        send(1'b0, 1'b0);
        chk("sync_one_cycle", 32'(sync_err), 32'h0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        chk("sync_valid", 32'(bus_a.dout_valid), 32'h1);
        chk("sync_dout",  32'(bus_a.dout),       32'hC);
        chk("sync_perr",  32'(bus_a.parity_err), 32'h0);
        tick();

        // Stalls between bits
        send_frame(4'hD, 1'b1, 3);
        chk("stall_valid", 32'(bus_a.dout_valid), 32'h1);
        chk("stall_dout",  32'(bus_a.dout),       32'hD);
        chk("stall_perr",  32'(bus_a.parity_err), 32'h0);
        tick();

        // Reset mid-frame while a word is also held
        bus_a.dout_ready = 1'b0;
        send_frame(4'hD, 1'b0, 0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("rst_dout",  32'(bus_a.dout),       32'h0);
        chk("rst_valid", 32'(bus_a.dout_valid), 32'h0);
        chk("rst_perr",  32'(bus_a.parity_err), 32'h0);
        rst = 1'b0;
        bus_a.dout_ready = 1'b1;
        send(1'b1, 1'b1);
        chk("rst_nosync", 32'(sync_err), 32'h0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        chk("rst_not_early", 32'(bus_a.dout_valid), 32'h0);
        send(1'b0, 1'b0);
        chk("rst_fresh_valid", 32'(bus_a.dout_valid), 32'h1);
        chk("rst_fresh_dout",  32'(bus_a.dout),       32'h3);
        chk("rst_fresh_perr",  32'(bus_a.parity_err), 32'h0);
        tick();

        // Instance B: N=8, no parity
        bus_b.dout_ready = 1'b1;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            send_b(pat[i], i == 0);
            if (i == 6) chk("b_not_early", 32'(bus_b.dout_valid), 32'h0);
        end
        chk("b_valid", 32'(bus_b.dout_valid), 32'h1);
        chk("b_dout",  32'(bus_b.dout),       32'hA5);
        chk("b_perr",  32'(bus_b.parity_err), 32'h0);
        tick();
        chk("b_xfer",  32'(bus_b.dout_valid), 32'h0);

        // Randomized frames against the model
        m_valid = bus_a.dout_valid;
        m_word  = 4'h0;
        m_perr  = 1'b0;
        for (int f = 0; f < 300; f++) begin
            logic [3:0] d;
            logic       p;
            bit         aborted;
            int         k;
            int         junk;
            d = 4'($urandom_range(0, 15));
            p = 1'($urandom_range(0, 1));
            // Bits without sof outside a frame must be ignored.
            junk = int'($urandom_range(0, 2));
            repeat (junk) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, rnd_ready(),
                               1'b0, 4'h0, 1'b0, 1'b0);
            // Sometimes start a partial frame (up to all data bits) first.
            aborted = ($urandom_range(0, 4) == 0);
            if (aborted) begin
                k = int'($urandom_range(1, 4));
                for (int j = 0; j < k; j++)
                    rbit(1'($urandom_range(0, 1)), j == 0, 1'b0, 4'h0, 1'b0, 1'b0);
            end
            for (int i = 0; i < 4; i++)
                rbit(d[i], i == 0, 1'b0, 4'h0, 1'b0, (i == 0) && aborted);
            rbit(p, 1'b0, 1'b1, d, ^{d, p}, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
